hack_kbd_ps2_ctrl: RTL and testbench

//  Keyboard-side producer for the Hack memory map's keyboard register (0x6000).

---
 rtl/hack_kbd_ps2_ctrl_pkg.sv | 51 +++++
 rtl/hack_kbd_ps2_ctrl_keymap.sv | 99 +++++++++
 rtl/hack_kbd_ps2_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_hack_kbd_ps2_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_kbd_ps2_ctrl_pkg.sv
// Shared types and constants for the Hack PS/2 keyboard controller:
// FSM state encodings, set-2 scancode prefixes and Hack special keycodes.
package hack_kbd_ps2_ctrl_pkg;

    typedef enum logic [1:0] {
        RX_WAIT_IDLE = 2'd0,
        RX_IDLE      = 2'd1,
        RX_SHIFT     = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        DEC_IDLE    = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_t;

    // Set-2 scancode prefixes and special bytes
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_PRTSC  = 8'h7C;

    // Hack special keycodes
    localparam logic [15:0] KC_SPACE = 16'd32;
    localparam logic [15:0] KC_ENTER = 16'd128;
    localparam logic [15:0] KC_BKSP  = 16'd129;
    localparam logic [15:0] KC_LEFT  = 16'd130;
    localparam logic [15:0] KC_UP    = 16'd131;
    localparam logic [15:0] KC_RIGHT = 16'd132;
    localparam logic [15:0] KC_DOWN  = 16'd133;
    localparam logic [15:0] KC_HOME  = 16'd134;
    localparam logic [15:0] KC_END   = 16'd135;
    localparam logic [15:0] KC_PGUP  = 16'd136;
    localparam logic [15:0] KC_PGDN  = 16'd137;
    localparam logic [15:0] KC_INS   = 16'd138;
    localparam logic [15:0] KC_DEL   = 16'd139;
    localparam logic [15:0] KC_ESC   = 16'd140;
    localparam logic [15:0] KC_F1    = 16'd141;

    // Shift keys are modifiers only; print-screen fake shifts are noise
    function automatic logic is_shift_key(input logic ext, input logic [7:0] sc);
        return !ext && (sc == SC_LSHIFT || sc == SC_RSHIFT);
    endfunction

    function automatic logic is_fake_shift(input logic ext, input logic [7:0] sc);
        return ext && (sc == SC_LSHIFT || sc == SC_PRTSC);
    endfunction

endpackage

// File: rtl/hack_kbd_ps2_ctrl_keymap.sv
// Combinational set-2 scancode to Hack keycode translation.
// Returns 0 for any scancode without a Hack meaning.
module hack_ps2_keymap
    import hack_kbd_ps2_ctrl_pkg::*;
(
    input  logic        ext,
    input  logic [7:0]  scancode,
    input  logic        shift,
    output logic [15:0] code
);

    // Pick the plain or shifted ASCII symbol for a punctuation/digit key
    function automatic logic [15:0] sym(input logic sh, input int plain, input int shifted);
        return sh ? 16'(shifted) : 16'(plain);
    endfunction

    // Lookup on {ext, scancode}; letters ignore shift, symbols honour it
    always_comb begin
        code = 16'd0;
        case ({ext, scancode})
            {1'b0, 8'h1C}: code = 16'd65;
            {1'b0, 8'h32}: code = 16'd66;
            {1'b0, 8'h21}: code = 16'd67;
            {1'b0, 8'h23}: code = 16'd68;
            {1'b0, 8'h24}: code = 16'd69;
            {1'b0, 8'h2B}: code = 16'd70;
            {1'b0, 8'h34}: code = 16'd71;
            {1'b0, 8'h33}: code = 16'd72;
            {1'b0, 8'h43}: code = 16'd73;
            {1'b0, 8'h3B}: code = 16'd74;
            {1'b0, 8'h42}: code = 16'd75;
            {1'b0, 8'h4B}: code = 16'd76;
            {1'b0, 8'h3A}: code = 16'd77;
            {1'b0, 8'h31}: code = 16'd78;
            {1'b0, 8'h44}: code = 16'd79;
            {1'b0, 8'h4D}: code = 16'd80;
            {1'b0, 8'h15}: code = 16'd81;
            {1'b0, 8'h2D}: code = 16'd82;
            {1'b0, 8'h1B}: code = 16'd83;
            {1'b0, 8'h2C}: code = 16'd84;
            {1'b0, 8'h3C}: code = 16'd85;
            {1'b0, 8'h2A}: code = 16'd86;
            {1'b0, 8'h1D}: code = 16'd87;
            {1'b0, 8'h22}: code = 16'd88;
            {1'b0, 8'h35}: code = 16'd89;
            {1'b0, 8'h1A}: code = 16'd90;
            {1'b0, 8'h16}: code = sym(shift, 49, 33);
            {1'b0, 8'h1E}: code = sym(shift, 50, 64);
            {1'b0, 8'h26}: code = sym(shift, 51, 35);
            {1'b0, 8'h25}: code = sym(shift, 52, 36);
            {1'b0, 8'h2E}: code = sym(shift, 53, 37);
            {1'b0, 8'h36}: code = sym(shift, 54, 94);
            {1'b0, 8'h3D}: code = sym(shift, 55, 38);
            {1'b0, 8'h3E}: code = sym(shift, 56, 42);
            {1'b0, 8'h46}: code = sym(shift, 57, 40);
            {1'b0, 8'h45}: code = sym(shift, 48, 41);
            {1'b0, 8'h0E}: code = sym(shift, 96, 126);
            {1'b0, 8'h4E}: code = sym(shift, 45, 95);
            {1'b0, 8'h55}: code = sym(shift, 61, 43);
            {1'b0, 8'h54}: code = sym(shift, 91, 123);
            {1'b0, 8'h5B}: code = sym(shift, 93, 125);
            {1'b0, 8'h5D}: code = sym(shift, 92, 124);
            {1'b0, 8'h4C}: code = sym(shift, 59, 58);
            {1'b0, 8'h52}: code = sym(shift, 39, 34);
            {1'b0, 8'h41}: code = sym(shift, 44, 60);
            {1'b0, 8'h49}: code = sym(shift, 46, 62);
            {1'b0, 8'h4A}: code = sym(shift, 47, 63);
            {1'b0, 8'h29}: code = KC_SPACE;
            {1'b0, 8'h5A}: code = KC_ENTER;
            {1'b0, 8'h66}: code = KC_BKSP;
            {1'b0, 8'h76}: code = KC_ESC;
            {1'b0, 8'h05}: code = KC_F1;
            {1'b0, 8'h06}: code = KC_F1 + 16'd1;
            {1'b0, 8'h04}: code = KC_F1 + 16'd2;
            {1'b0, 8'h0C}: code = KC_F1 + 16'd3;
            {1'b0, 8'h03}: code = KC_F1 + 16'd4;
            {1'b0, 8'h0B}: code = KC_F1 + 16'd5;
            {1'b0, 8'h83}: code = KC_F1 + 16'd6;
            {1'b0, 8'h0A}: code = KC_F1 + 16'd7;
            {1'b0, 8'h01}: code = KC_F1 + 16'd8;
            {1'b0, 8'h09}: code = KC_F1 + 16'd9;
            {1'b0, 8'h78}: code = KC_F1 + 16'd10;
            {1'b0, 8'h07}: code = KC_F1 + 16'd11;
            {1'b1, 8'h5A}: code = KC_ENTER;
            {1'b1, 8'h6B}: code = KC_LEFT;
            {1'b1, 8'h75}: code = KC_UP;
            {1'b1, 8'h74}: code = KC_RIGHT;
            {1'b1, 8'h72}: code = KC_DOWN;
            {1'b1, 8'h6C}: code = KC_HOME;
            {1'b1, 8'h69}: code = KC_END;
            {1'b1, 8'h7D}: code = KC_PGUP;
            {1'b1, 8'h7A}: code = KC_PGDN;
            {1'b1, 8'h70}: code = KC_INS;
            {1'b1, 8'h71}: code = KC_DEL;
            default:       code = 16'd0;
        endcase
    end

endmodule

// File: rtl/hack_kbd_ps2_ctrl.sv
// PS/2 keyboard front end for the Hack keyboard register: conditions the
// PS/2 lines, receives device-to-host frames, decodes set-2 make/break
// sequences and holds the Hack keycode of the last pressed key on kbOut.
module hack_kbd_ps2_ctrl #(
    parameter int TIMEOUT_CYC = 64000,
    parameter int FILTER_LEN  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kbOut,
    output logic        key_strobe,
    output logic        frame_err
);
    import hack_kbd_ps2_ctrl_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;
    logic          data_bit;

    rx_state_t     rx_q, rx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d;
    logic          par_q, par_d;
    logic          byte_vld_q, byte_vld_d;
    logic          err_q, err_d;

    dec_state_t    dec_q, dec_d;
    logic          dec_ext, dec_brk;
    logic          shift_q, shift_d;
    logic [15:0]   kb_q, kb_d;
    logic [8:0]    held_q, held_d;
    logic          strobe_q, strobe_d;
    logic [15:0]   map_code;

    assign kbOut      = kb_q;
    assign key_strobe = strobe_q;
    assign frame_err  = err_q;
    assign data_bit   = data_sync_q[1];
    assign fall       = filt_q & ~filt_d;
    assign dec_ext    = (dec_q == DEC_EXT) || (dec_q == DEC_EXT_BRK);
    assign dec_brk    = (dec_q == DEC_BRK) || (dec_q == DEC_EXT_BRK);

    hack_ps2_keymap u_keymap (
        .ext      (dec_ext),
        .scancode (sr_q),
        .shift    (shift_q),
        .code     (map_code)
    );

    // Synchronizers shift in the raw lines; the filter flips only after FILTER_LEN disagreeing samples
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_d      = filt_q;
        fcnt_d      = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Receiver: idle-line qualification, frame shifting, parity/stop/timeout checks
    always_comb begin
        rx_d       = rx_q;
        tmo_d      = tmo_q;
        bit_d      = bit_q;
        sr_d       = sr_q;
        par_d      = par_q;
        byte_vld_d = 1'b0;
        err_d      = 1'b0;
        case (rx_q)
            RX_WAIT_IDLE: begin
                if (!filt_q) begin
                    tmo_d = '0;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_d = '0;
                    rx_d  = RX_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RX_IDLE: begin
                tmo_d = '0;
                if (fall) begin
                    if (!data_bit) begin
                        rx_d  = RX_SHIFT;
                        bit_d = 4'd0;
                        par_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                        rx_d  = RX_WAIT_IDLE;
                    end
                end
            end
            RX_SHIFT: begin
                if (fall) begin
                    tmo_d = '0;
                    if (bit_q < 4'd8) begin
                        sr_d  = {data_bit, sr_q[7:1]};
                        par_d = par_q ^ data_bit;
                        bit_d = bit_q + 4'd1;
                    end else if (bit_q == 4'd8) begin
                        par_d = par_q ^ data_bit;
                        bit_d = 4'd9;
                    end else begin
                        bit_d = 4'd0;
                        if (data_bit && par_q) begin
                            byte_vld_d = 1'b1;
                            rx_d       = RX_IDLE;
                        end else begin
                            err_d = 1'b1;
                            rx_d  = RX_WAIT_IDLE;
                        end
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC)) begin
                    tmo_d = '0;
                    bit_d = 4'd0;
                    err_d = 1'b1;
                    rx_d  = RX_WAIT_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: rx_d = RX_WAIT_IDLE;
        endcase
    end

    // Decoder: track E0/F0 prefixes, resolve make/break into shift state and held key
    always_comb begin
        dec_d  = dec_q;
        shift_d = shift_q;
        kb_d   = kb_q;
        held_d = held_q;
        if (byte_vld_q) begin
            if (sr_q == SC_EXT && dec_q == DEC_IDLE) begin
                dec_d = DEC_EXT;
            end else if (sr_q == SC_EXT && dec_brk) begin
                dec_d = dec_q;
            end else if (sr_q == SC_BRK && dec_q == DEC_IDLE) begin
                dec_d = DEC_BRK;
            end else if (sr_q == SC_BRK && dec_q == DEC_EXT) begin
                dec_d = DEC_EXT_BRK;
            end else begin
                dec_d = DEC_IDLE;
                if (is_shift_key(dec_ext, sr_q)) begin
                    shift_d = !dec_brk;
                end else if (is_fake_shift(dec_ext, sr_q)) begin
                    shift_d = shift_q;
                end else if (!dec_brk) begin
                    if (map_code != 16'd0) begin
                        kb_d   = map_code;
                        held_d = {dec_ext, sr_q};
                    end
                end else if (held_q == {dec_ext, sr_q}) begin
                    kb_d   = 16'd0;
                    held_d = 9'd0;
                end
            end
        end
        strobe_d = (kb_d != kb_q);
    end

    // State and output registers, all cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            rx_q        <= RX_WAIT_IDLE;
            tmo_q       <= '0;
            bit_q       <= 4'd0;
            sr_q        <= 8'd0;
            par_q       <= 1'b0;
            byte_vld_q  <= 1'b0;
            err_q       <= 1'b0;
            dec_q       <= DEC_IDLE;
            shift_q     <= 1'b0;
            kb_q        <= 16'd0;
            held_q      <= 9'd0;
            strobe_q    <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            rx_q        <= rx_d;
            tmo_q       <= tmo_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            par_q       <= par_d;
            byte_vld_q  <= byte_vld_d;
            err_q       <= err_d;
            dec_q       <= dec_d;
            shift_q     <= shift_d;
            kb_q        <= kb_d;
            held_q      <= held_d;
            strobe_q    <= strobe_d;
        end
    end

endmodule

// File: tb/tb_hack_kbd_ps2_ctrl.sv
// Self-checking bench for hack_kbd_ps2_ctrl: drives PS/2 frames and checks
// every key_strobe against a queue of expected kbOut values.
`timescale 1ns/1ps
module tb_hack_kbd_ps2_ctrl;

    localparam int TMO  = 400;
    localparam int HALF = 40;

    logic        clk;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] kbOut;
    logic        key_strobe;
    logic        frame_err;

    int          vectors;
    int          miscompares;
    int          err_seen;
    logic [15:0] exp_q[$];

    hack_kbd_ps2_ctrl #(.TIMEOUT_CYC(TMO), .FILTER_LEN(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .kbOut      (kbOut),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    // 100 MHz bench clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the next expected kbOut value
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) err_seen++;
            if (key_strobe) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL strobe_unexpected: kbOut=%0d, no strobe required", kbOut);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (kbOut !== e) begin
                        miscompares++;
                        $display("[TB] FAIL strobe_value: kbOut=%0d, required %0d", kbOut, e);
                    end
                end
            end
        end
    end

    // Hang guard
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send the first nbits bits of a frame: start, 8 data LSB first, odd parity, stop
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        logic        p;
        p  = ~(^b) ^ bad_par;
        fr = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_cyc(5);
        vectors++;
        if (kbOut !== 16'd0 || key_strobe !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: kbOut=%0d strobe=%b err=%b, required 0 0 0", kbOut, key_strobe, frame_err);
        end
        reset = 1'b0;
        wait_cyc(TMO + 50);
        vectors++;
        if (kbOut !== 16'd0 || err_seen !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: kbOut=%0d errs=%0d, required 0 0", kbOut, err_seen);
        end
    endtask

    task automatic test_make_break();
        int e0;
        e0 = err_seen;
        exp_q.push_back(16'd65);
        send(8'h1C);
        vectors++;
        if (kbOut !== 16'd65) begin
            miscompares++;
            $display("[TB] FAIL make_A: kbOut=%0d, required 65", kbOut);
        end
        exp_q.push_back(16'd0);
        send(8'hF0); send(8'h1C);
        vectors++;
        if (kbOut !== 16'd0 || err_seen !== e0 || exp_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL break_A: kbOut=%0d errs=%0d pending=%0d, required 0 %0d 0", kbOut, err_seen, exp_q.size(), e0);
        end
    endtask

    task automatic test_extended();
        exp_q.push_back(16'd130);
        send(8'hE0); send(8'h6B);
        vectors++;
        if (kbOut !== 16'd130) begin
            miscompares++;
            $display("[TB] FAIL make_left: kbOut=%0d, required 130", kbOut);
        end
        exp_q.push_back(16'd0);
        send(8'hE0); send(8'hF0); send(8'h6B);
        vectors++;
        if (kbOut !== 16'd0 || exp_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL break_left: kbOut=%0d pending=%0d, required 0 0", kbOut, exp_q.size());
        end
    endtask

    task automatic test_shift();
        send(8'h12);
        exp_q.push_back(16'd33);
        send(8'h16);
        vectors++;
        if (kbOut !== 16'd33) begin
            miscompares++;
            $display("[TB] FAIL shift_bang: kbOut=%0d, required 33", kbOut);
        end
        exp_q.push_back(16'd0);
        send(8'hF0); send(8'h16);
        send(8'hF0); send(8'h12);
        exp_q.push_back(16'd49);
        send(8'h16);
        vectors++;
        if (kbOut !== 16'd49) begin
            miscompares++;
            $display("[TB] FAIL unshift_one: kbOut=%0d, required 49", kbOut);
        end
        exp_q.push_back(16'd0);
        send(8'hF0); send(8'h16);
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL shift_pending: %0d strobes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_parity_err();
        int e0;
        e0 = err_seen;
        send_frame(8'h1C, 1'b1, 11);
        vectors++;
        if (err_seen !== e0 + 1 || kbOut !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL parity_err: errs=%0d kbOut=%0d, required %0d 0", err_seen, kbOut, e0 + 1);
        end
        wait_cyc(TMO + 50);
        exp_q.push_back(16'd65);
        send(8'h1C);
        vectors++;
        if (kbOut !== 16'd65 || err_seen !== e0 + 1) begin
            miscompares++;
            $display("[TB] FAIL parity_recover: kbOut=%0d errs=%0d, required 65 %0d", kbOut, err_seen, e0 + 1);
        end
        exp_q.push_back(16'd0);
        send(8'hF0); send(8'h1C);
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(16'd65);
        send(8'h1C);
        exp_q.push_back(16'd66);
        send(8'h32);
        send(8'hF0); send(8'h1C);
        vectors++;
        if (kbOut !== 16'd66) begin
            miscompares++;
            $display("[TB] FAIL last_key_wins: kbOut=%0d, required 66", kbOut);
        end
        exp_q.push_back(16'd0);
        send(8'hF0); send(8'h32);
        exp_q.push_back(16'd65);
        for (int i = 0; i < 3; i++) send(8'h1C);
        vectors++;
        if (kbOut !== 16'd65 || exp_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL typematic: kbOut=%0d pending=%0d, required 65 0", kbOut, exp_q.size());
        end
        exp_q.push_back(16'd0);
        send(8'hF0); send(8'h1C);
    endtask

    task automatic test_timeout_reset();
        int e0;
        e0 = err_seen;
        send_frame(8'h5A, 1'b0, 5);
        wait_cyc(2 * TMO + 100);
        vectors++;
        if (err_seen !== e0 + 1 || kbOut !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL timeout_err: errs=%0d kbOut=%0d, required %0d 0", err_seen, kbOut, e0 + 1);
        end
        exp_q.push_back(16'd128);
        send(8'h5A);
        vectors++;
        if (kbOut !== 16'd128) begin
            miscompares++;
            $display("[TB] FAIL enter_after_timeout: kbOut=%0d, required 128", kbOut);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (kbOut !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: kbOut=%0d, required 0", kbOut);
        end
        wait_cyc(3);
        vectors++;
        if (kbOut !== 16'd0 || key_strobe !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL in_reset: kbOut=%0d strobe=%b err=%b, required 0 0 0", kbOut, key_strobe, frame_err);
        end
        reset = 1'b0;
        wait_cyc(10);
        vectors++;
        if (kbOut !== 16'd0 || exp_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL after_reset: kbOut=%0d pending=%0d, required 0 0", kbOut, exp_q.size());
        end
    endtask

    // Scenario sequence
    initial begin
        vectors = 0; miscompares = 0; err_seen = 0;
        test_reset();
        test_make_break();
        test_extended();
        test_shift();
        test_parity_err();
        test_back_to_back();
        test_timeout_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
